// File: rtl/arbitro_memoria.sv
// rtl/arbitro_memoria.sv - two-port fetch/data arbiter onto a single memory channel with watchdog (optional ARB_ROUND_ROBIN_EN)
module arbitro_memoria #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_WAIT = 2'd1,
        DM_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    // Abort fires on the edge where the counter would reach the limit,
    // so mem_req stays high for exactly TIMEOUT_CYCLES cycles.
    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic [7:0]        wd_cnt;
    logic              abort_q;
    logic              grant_dm_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              dm_pending;
    logic              pick_dm;
    logic              in_wait;
    logic              timeout_hit;

    assign dm_pending  = dm_read | dm_write;
    assign in_wait     = (state == IF_WAIT) || (state == DM_WAIT);
    // mem_ack takes precedence over the watchdog in the same cycle
    assign timeout_hit = in_wait && !mem_ack && (wd_cnt == WD_LIMIT);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_dm_q;

    // On a tie the port that was not served last wins
    assign pick_dm = dm_pending && (!if_req || !last_dm_q);

    // Remember which port received the most recent grant
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_dm_q <= 1'b0;
        end else if (state == IDLE) begin
            if (pick_dm) begin
                last_dm_q <= 1'b1;
            end else if (if_req) begin
                last_dm_q <= 1'b0;
            end
        end
    end
`else
    // Fixed priority: the data port always wins a tie
    assign pick_dm = dm_pending;
`endif

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q & in_wait;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        if_ready   = 1'b0;
        dm_ready   = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                if (pick_dm) begin
                    state_next = DM_WAIT;
                end else if (if_req) begin
                    state_next = IF_WAIT;
                end
            end
            IF_WAIT, DM_WAIT: begin
                mem_req = 1'b1;
                if (mem_ack || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if_ready   = ~grant_dm_q;
                dm_ready   = grant_dm_q;
                err        = abort_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latching, watchdog and response capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            wd_cnt     <= '0;
            abort_q    <= 1'b0;
            grant_dm_q <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wd_cnt  <= '0;
                    abort_q <= 1'b0;
                    if (pick_dm) begin
                        addr_q     <= dm_addr;
                        wdata_q    <= dm_wdata;
                        we_q       <= dm_write;
                        grant_dm_q <= 1'b1;
                    end else if (if_req) begin
                        addr_q     <= if_addr;
                        wdata_q    <= '0;
                        we_q       <= 1'b0;
                        grant_dm_q <= 1'b0;
                    end
                end
                IF_WAIT, DM_WAIT: begin
                    if (mem_ack) begin
                        if (!we_q) begin
                            if (grant_dm_q) begin
                                dm_rdata_q <= mem_rdata;
                            end else begin
                                if_rdata_q <= mem_rdata;
                            end
                        end
                    end else if (timeout_hit) begin
                        abort_q <= 1'b1;
                        if (!we_q) begin
                            if (grant_dm_q) begin
                                dm_rdata_q <= '0;
                            end else begin
                                if_rdata_q <= '0;
                            end
                        end
                    end else if (wd_cnt != 8'hFF) begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
